// File: rtl/trigger_pkg.sv
// Shared types for the sequential trigger: compare modes and sequencer states.
package trigger_pkg;

   typedef enum logic [1:0] {
      LEVEL  = 2'd0,
      RISE   = 2'd1,
      FALL   = 2'd2,
      CHANGE = 2'd3
   } trig_mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      FIRED = 2'd2
   } seq_state_e;

endpackage

// File: rtl/trigger_stage_match.sv
// One sequence stage: masks the probe, keeps last cycle's masked value and
// evaluates the stage condition for the configured mode. The previous-value
// register runs in every sequencer state so edge modes are valid on arm.
module trigger_stage_match
   import trigger_pkg::*;
#(
   parameter int PROBE_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PROBE_W-1:0] probe_data,
   input  logic [PROBE_W-1:0] value,
   input  logic [PROBE_W-1:0] mask,
   input  trig_mode_e         mode,
   output logic               match
);

   logic [PROBE_W-1:0] mp;
   logic [PROBE_W-1:0] mp_d_q;
   logic [PROBE_W-1:0] mp_d_d;

   assign mp     = probe_data & mask;
   assign mp_d_d = mp;

   // Condition for the selected mode, purely combinational.
   always_comb begin
      match = 1'b0;
      unique case (mode)
         LEVEL:  match = (mp == (value & mask));
         RISE:   match = (mp_d_q == '0) && (mp != '0);
         FALL:   match = (mp_d_q != '0) && (mp == '0);
         CHANGE: match = (mp != mp_d_q);
         default: match = 1'b0;
      endcase
   end

   // Previous masked probe, sampled every cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) mp_d_q <= '0;
      else     mp_d_q <= mp_d_d;
   end

endmodule

// File: rtl/trigger_seq_unit.sv
// Multi-stage sequential trigger. Walks stages 0..cfg_last_stage in order,
// each stage needing cfg_count occurrences of its condition, and pulses
// trigger_hit for one cycle on completion.
// Optional macro TRIG_TIMEOUT_EN adds a per-stage timeout back to stage 0.
module trigger_seq_unit
   import trigger_pkg::*;
#(
   parameter int PROBE_W    = 32,
   parameter int NUM_STAGES = 4,
   parameter int CNT_W      = 8,
   parameter int TO_W       = 16,
   parameter int STG_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [PROBE_W-1:0]            probe_data,
   input  logic                          arm,
   input  logic                          disarm,
   input  logic [NUM_STAGES*PROBE_W-1:0] cfg_value,
   input  logic [NUM_STAGES*PROBE_W-1:0] cfg_mask,
   input  logic [NUM_STAGES*2-1:0]       cfg_mode,
   input  logic [NUM_STAGES*CNT_W-1:0]   cfg_count,
   input  logic [STG_W-1:0]              cfg_last_stage,
   input  logic [TO_W-1:0]               cfg_timeout,
   output logic                          trigger_hit,
   output logic                          armed,
   output logic                          fired,
   output logic [STG_W-1:0]              cur_stage
);

   seq_state_e       state_q, state_d;
   logic [STG_W-1:0] stage_q, stage_d;
   logic [CNT_W-1:0] occ_q, occ_d;
   logic             hit_q, hit_d;

   logic [NUM_STAGES-1:0] match;
   logic [CNT_W-1:0]      cnt_arr [NUM_STAGES];

   logic             cond;
   logic [CNT_W-1:0] cnt_sel;
   logic [CNT_W:0]   cnt_req;
   logic             complete;
   logic [STG_W-1:0] last_stg;
   logic             timeout_hit;

   // Per-stage condition evaluators.
   for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
      trigger_stage_match #(.PROBE_W(PROBE_W)) u_match (
         .clk        (clk),
         .rst        (rst),
         .probe_data (probe_data),
         .value      (cfg_value[i*PROBE_W +: PROBE_W]),
         .mask       (cfg_mask[i*PROBE_W +: PROBE_W]),
         .mode       (trig_mode_e'(cfg_mode[i*2 +: 2])),
         .match      (match[i])
      );
      assign cnt_arr[i] = cfg_count[i*CNT_W +: CNT_W];
   end

   assign cond    = match[stage_q];
   assign cnt_sel = cnt_arr[stage_q];
   // A zero count means "one occurrence".
   assign cnt_req = (cnt_sel == '0) ? (CNT_W+1)'(1) : {1'b0, cnt_sel};
   assign complete = cond && (({1'b0, occ_q} + (CNT_W+1)'(1)) >= cnt_req);

   // Out-of-range final stage collapses onto the last physical stage.
   assign last_stg = ({1'b0, cfg_last_stage} > (STG_W+1)'(NUM_STAGES-1))
                     ? STG_W'(NUM_STAGES-1) : cfg_last_stage;

`ifdef TRIG_TIMEOUT_EN
   logic [TO_W-1:0] tmr_q, tmr_d;

   assign timeout_hit = (cfg_timeout != '0) && (stage_q != '0) &&
                        (({1'b0, tmr_q} + (TO_W+1)'(1)) >= {1'b0, cfg_timeout});

   // Stage timer: runs only while waiting in a stage beyond the first.
   always_comb begin
      tmr_d = tmr_q;
      if (disarm || arm || state_q != ARMED || stage_q == '0 || complete || timeout_hit)
         tmr_d = '0;
      else if (tmr_q != '1)
         tmr_d = tmr_q + TO_W'(1);
   end

   // Timer register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) tmr_q <= '0;
      else     tmr_q <= tmr_d;
   end
`else
   logic unused_timeout;
   assign unused_timeout = ^cfg_timeout;
   assign timeout_hit    = 1'b0;
`endif

   // Sequencer next state: disarm beats arm, arm beats any stage progress,
   // and stage completion beats a same-cycle timeout.
   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      occ_d   = occ_q;
      hit_d   = 1'b0;
      if (disarm) begin
         state_d = IDLE;
         stage_d = '0;
         occ_d   = '0;
      end else if (arm) begin
         state_d = ARMED;
         stage_d = '0;
         occ_d   = '0;
      end else if (state_q == ARMED) begin
         if (complete) begin
            occ_d = '0;
            if (stage_q == last_stg) begin
               state_d = FIRED;
               hit_d   = 1'b1;
            end else begin
               stage_d = stage_q + STG_W'(1);
            end
         end else if (timeout_hit) begin
            stage_d = '0;
            occ_d   = '0;
         end else if (cond && occ_q != '1) begin
            occ_d = occ_q + CNT_W'(1);
         end
      end
   end

   // Sequencer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         stage_q <= '0;
         occ_q   <= '0;
         hit_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         occ_q   <= occ_d;
         hit_q   <= hit_d;
      end
   end

   assign trigger_hit = hit_q;
   assign armed       = (state_q == ARMED);
   assign fired       = (state_q == FIRED);
   assign cur_stage   = stage_q;

endmodule

// File: tb/tb_trigger_seq_unit.sv
// Directed bench for trigger_seq_unit: single-stage, edge-sequence, count,
// control precedence, reset, CHANGE masking and (with TRIG_TIMEOUT_EN) timeout.
module tb_trigger_seq_unit;
   localparam int PW = 32;
   localparam int NS = 4;
   localparam int CW = 8;
   localparam int TW = 16;
   localparam int SW = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [PW-1:0]    probe_data;
   logic             arm, disarm;
   logic [NS*PW-1:0] cfg_value, cfg_mask;
   logic [NS*2-1:0]  cfg_mode;
   logic [NS*CW-1:0] cfg_count;
   logic [SW-1:0]    cfg_last_stage;
   logic [TW-1:0]    cfg_timeout;
   logic             trigger_hit, armed, fired;
   logic [SW-1:0]    cur_stage;

   int n_tests = 0;
   int n_fail  = 0;

   trigger_seq_unit dut (
      .clk(clk), .rst(rst), .probe_data(probe_data), .arm(arm), .disarm(disarm),
      .cfg_value(cfg_value), .cfg_mask(cfg_mask), .cfg_mode(cfg_mode),
      .cfg_count(cfg_count), .cfg_last_stage(cfg_last_stage),
      .cfg_timeout(cfg_timeout), .trigger_hit(trigger_hit), .armed(armed),
      .fired(fired), .cur_stage(cur_stage)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Check {trigger_hit, armed, fired, cur_stage} in one go.
   task automatic chk_out(input string tag, input logic h, input logic a,
                          input logic f, input logic [SW-1:0] s);
      chk(tag, {27'd0, trigger_hit, armed, fired, cur_stage}, {27'd0, h, a, f, s});
   endtask

   task automatic set_stage(input int i, input logic [PW-1:0] v, input logic [PW-1:0] m,
                            input logic [1:0] md, input logic [CW-1:0] c);
      cfg_value[i*PW +: PW] = v;
      cfg_mask[i*PW +: PW]  = m;
      cfg_mode[i*2 +: 2]    = md;
      cfg_count[i*CW +: CW] = c;
   endtask

   initial begin
      rst = 1'b1; probe_data = '0; arm = 0; disarm = 0;
      cfg_value = '0; cfg_mask = '0; cfg_mode = '0; cfg_count = '0;
      cfg_last_stage = '0; cfg_timeout = '0;
      #12;
      chk_out("reset", 0, 0, 0, 0);
      rst = 1'b0;
      tick();

      // 1: single LEVEL stage
      set_stage(0, 32'hA5, 32'hFF, 2'd0, 8'd1);
      arm = 1; tick(); arm = 0;
      chk_out("t1_armed", 0, 1, 0, 0);
      tick();
      chk_out("t1_nomatch", 0, 1, 0, 0);
      probe_data = 32'hA5; tick();
      chk_out("t1_hit", 1, 0, 1, 0);
      probe_data = 0; tick();
      chk_out("t1_hit_one_cycle", 0, 0, 1, 0);

      // 2: RISE then FALL on bit 0, with an early fall ignored
      cfg_last_stage = 2'd1;
      set_stage(0, 0, 32'h1, 2'd1, 8'd1);
      set_stage(1, 0, 32'h1, 2'd2, 8'd1);
      probe_data = 1; tick();
      arm = 1; tick(); arm = 0;
      probe_data = 0; tick();
      chk_out("t2_fall_first", 0, 1, 0, 0);
      probe_data = 1; tick();
      chk_out("t2_rise_adv", 0, 1, 0, 1);
      tick(); tick();
      chk_out("t2_hold", 0, 1, 0, 1);
      probe_data = 0; tick();
      chk_out("t2_fall_hit", 1, 0, 1, 1);

      // 3: occurrence count of 3 with a gap, then count 0 acting as 1
      cfg_last_stage = 2'd0;
      set_stage(0, 32'hA5, 32'hFF, 2'd0, 8'd3);
      arm = 1; tick(); arm = 0;
      probe_data = 32'hA5; tick(); tick();
      chk_out("t3_two_matches", 0, 1, 0, 0);
      probe_data = 0; tick();
      chk_out("t3_gap", 0, 1, 0, 0);
      probe_data = 32'hA5; tick();
      chk_out("t3_third_hit", 1, 0, 1, 0);
      set_stage(0, 32'hA5, 32'hFF, 2'd0, 8'd0);
      probe_data = 0;
      arm = 1; tick(); arm = 0;
      probe_data = 32'hA5; tick();
      chk_out("t3_count0", 1, 0, 1, 0);

      // 4: arm+disarm, arm while ARMED, re-arm in FIRED, reset mid-stage-1
      arm = 1; disarm = 1; tick(); arm = 0; disarm = 0;
      chk_out("t4_disarm_wins", 0, 0, 0, 0);
      arm = 1; tick();
      chk_out("t4_armed_match_held", 0, 1, 0, 0);
      tick();
      chk_out("t4_rearm_no_hit", 0, 1, 0, 0);
      arm = 0; tick();
      chk_out("t4_hit_after_rearm", 1, 0, 1, 0);
      probe_data = 0; arm = 1; tick(); arm = 0;
      chk_out("t4_rearm_fired", 0, 1, 0, 0);
      cfg_last_stage = 2'd1;
      set_stage(1, 32'h3C, 32'hFF, 2'd0, 8'd1);
      probe_data = 32'hA5; tick();
      chk_out("t4_stage1", 0, 1, 0, 1);
      probe_data = 32'h3C;
      #2 rst = 1'b1;
      #1;
      chk_out("t4_async_reset", 0, 0, 0, 0);
      tick();
      chk_out("t4_reset_held", 0, 0, 0, 0);
      rst = 1'b0;

      // 5: CHANGE on upper nibble only
      cfg_last_stage = 2'd0;
      set_stage(0, 0, 32'hF0, 2'd3, 8'd1);
      probe_data = 0; tick();
      arm = 1; tick(); arm = 0;
      probe_data = 32'h0F; tick();
      chk_out("t5_low_change", 0, 1, 0, 0);
      probe_data = 32'h1F; tick();
      chk_out("t5_high_change", 1, 0, 1, 0);

`ifdef TRIG_TIMEOUT_EN
      // 6: timeout back to stage 0, and completion beating the timeout
      cfg_timeout = 16'd5;
      cfg_last_stage = 2'd1;
      set_stage(0, 32'hA5, 32'hFF, 2'd0, 8'd1);
      set_stage(1, 32'h3C, 32'hFF, 2'd0, 8'd1);
      probe_data = 0;
      arm = 1; tick(); arm = 0;
      probe_data = 32'hA5; tick();
      chk_out("t6_adv", 0, 1, 0, 1);
      probe_data = 0;
      tick(); tick(); tick(); tick();
      chk_out("t6_before_to", 0, 1, 0, 1);
      tick();
      chk_out("t6_timeout", 0, 1, 0, 0);
      probe_data = 32'hA5; tick();
      probe_data = 0;
      tick(); tick(); tick(); tick();
      probe_data = 32'h3C; tick();
      chk_out("t6_adv_wins", 1, 0, 1, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/trigger_seq_unit.md
Name: trigger_seq_unit

Overview:
Multi-stage sequential trigger for the event monitor. It extends single-condition matching to a programmable chain of up to NUM_STAGES conditions, each with its own value, mask, mode and occurrence count. The chain must be satisfied in order before the block emits a one-cycle trigger_hit. It sits between the probe mux and the capture/event logic, and is armed and disarmed by the control register block.

Parameters:
PROBE_W, 32, probe and compare width
NUM_STAGES, 4, number of sequence stages (≥1)
CNT_W, 8, width of per-stage occurrence count
TO_W, 16, width of stage timeout counter
STG_W, $clog2(NUM_STAGES) (min 1), derived stage index width

Ports:
clk  in  1  single clock
rst  in  1  reset, asynchronous, active-high
probe_data  in  PROBE_W  probed signal
arm  in  1  pulse: start sequence at stage 0
disarm  in  1  pulse: return to IDLE
cfg_value  in  NUM_STAGES*PROBE_W  per-stage compare value, stage i at [i*PROBE_W +: PROBE_W]
cfg_mask  in  NUM_STAGES*PROBE_W  per-stage mask, same packing
cfg_mode  in  NUM_STAGES*2  per-stage mode
cfg_count  in  NUM_STAGES*CNT_W  per-stage required occurrences
cfg_last_stage  in  STG_W  index of final stage
cfg_timeout  in  TO_W  stage timeout in cycles (used only with TRIG_TIMEOUT_EN)
trigger_hit  out  1  one-cycle pulse on sequence completion
armed  out  1  high in ARMED
fired  out  1  high in FIRED
cur_stage  out  STG_W  active stage index

Behaviour:
- One clock. Reset is asynchronous and active-high.
- Reset values:
  - State is IDLE.
  - trigger_hit=0, armed=0, fired=0, cur_stage=0.
  - All counters and previous-probe registers are 0.
- Masked probe: mp = probe_data & mask[i]. Previous mp_d[i] is registered every cycle in all states.
- Modes:
  - 0 LEVEL: mp == value & mask.
  - 1 RISE: mp_d == 0 && mp != 0.
  - 2 FALL: mp_d != 0 && mp == 0.
  - 3 CHANGE: mp != mp_d.
- Conditions are evaluated combinationally and acted on at the clock edge. Only the current stage's condition is used.
- FSM:
  - IDLE: arm → ARMED, cur_stage=0, occ=0.
  - ARMED: each cycle the stage condition is true, occ++.
    - When occ+1 ≥ max(cfg_count[i],1), the stage completes.
    - If cur_stage == cfg_last_stage: → FIRED and trigger_hit=1 for exactly the next cycle.
    - Otherwise: cur_stage++ and occ=0. The next stage is evaluated from the following cycle; at most one stage advances per cycle.
  - FIRED: holds (fired=1) until arm (→ ARMED, stage 0) or disarm (→ IDLE).
- Latency: a final-stage match sampled at edge N produces trigger_hit high from edge N to edge N+1.
- Edge cases:
  - Simultaneous arm and disarm: disarm wins.
  - arm while ARMED: restart at stage 0, occ=0. No trigger_hit that cycle, even if the completion condition held.
  - cfg_last_stage ≥ NUM_STAGES: clamp to NUM_STAGES-1.
  - cfg_count=0: treated as 1.
  - occ saturates and never wraps.
  - Config inputs are live. Changing them mid-sequence affects the next evaluation; there is no shadowing.
  - Async reset mid-sequence: immediate return to the reset state. Any pending trigger_hit is dropped.

Optional Feature:
TRIG_TIMEOUT_EN:
- Defined:
  - A stage timer counts cycles in ARMED at cur_stage>0. It clears on every stage advance and on arm.
  - When the timer reaches cfg_timeout (nonzero), the sequence returns to stage 0 with occ=0 and stays ARMED.
  - cfg_timeout=0 disables the timeout.
  - Stage completion on the same cycle as the timeout wins.
- Undefined: no timer logic; cfg_timeout is ignored.

Decomposition:
- Package trigger_pkg:
  - trig_mode_e enum (LEVEL, RISE, FALL, CHANGE).
  - seq_state_e enum (IDLE, ARMED, FIRED).
- Sub-module trigger_stage_match: per-stage masked compare and mode evaluation, owning its mp_d register. Instantiated NUM_STAGES times via generate.
- The top level owns the FSM, the occurrence counter and the timer.

Test Plan:
1. Single stage: cfg_last_stage=0, mode LEVEL, value=0xA5, mask=0xFF, count=1; arm, then drive probe=0xA5 → trigger_hit pulses 1 cycle after the sample; fired=1; armed=0.
2. Two-stage RISE then FALL: mask=0x1; probe bit0 goes 0→1, then 1→0 three cycles later → cur_stage 0→1 after the rise; trigger_hit 1 cycle after the fall. A fall before the rise gives no hit.
3. Count: stage 0 LEVEL, count=3; probe matches 2 cycles, then 1 mismatch, then 1 match → trigger on the 3rd cumulative match. count=0 behaves as 1.
4. Control precedence: arm+disarm in the same cycle → IDLE. Re-arm in FIRED → ARMED, cur_stage=0, no spurious hit. Reset asserted mid-stage 1 → all outputs 0 immediately.
5. CHANGE mode with mask=0xF0: a probe change in 0x0F only → no hit; a change in 0xF0 → hit.
6. (TRIG_TIMEOUT_EN) cfg_timeout=5; stage 0 matches, stage 1 never matches → returns to cur_stage 0 after 5 cycles, armed=1; a stage-1 match on cycle 5 → advance wins.
